// File: rtl/vga_mem_arbiter.sv
// ============================================================================
//  Module   : vga_mem_arbiter
//  Purpose  : Shares one single-port synchronous RAM between the VGA pixel
//             fetch unit (read only) and the CPU load/store port. One access
//             is granted per clock, VGA first, CPU on the remaining slots.
//             The RAM port is driven from registers and read data is steered
//             back to its owner through a two-stage owner-tag pipeline, for a
//             fixed grant-to-rvalid latency of 3 cycles.
//  Build option:
//             MEM_ARB_STARVE_GUARD_EN - when defined, an 8-bit wait counter
//             forces a CPU grant after STARVE_MAX consecutive lost
//             arbitrations. When undefined, priority is strictly VGA > CPU.
//  Ports    :
//    clk, reset                 clock, asynchronous active-high reset
//    vga_req/vga_addr           VGA read request (held until granted)
//    vga_gnt                    VGA accepted this cycle (combinational)
//    vga_rvalid/vga_rdata       VGA read return
//    cpu_req/cpu_we/cpu_addr/cpu_wdata
//                               CPU request (held until granted)
//    cpu_gnt                    CPU accepted this cycle (combinational)
//    cpu_rvalid/cpu_rdata       CPU read return
//    mem_en/mem_we/mem_addr/mem_wdata
//                               registered RAM command
//    mem_rdata                  RAM read data, one cycle after a read strobe
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    // VGA pixel fetch port
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    // CPU load/store port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_t              tag1_q,      tag1_d;
    tag_t              tag2_q;
    logic              vga_rvalid_q;
    logic [DATA_W-1:0] vga_rdata_q;
    logic              cpu_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    // High when the starvation guard overrides VGA priority this cycle.
    logic              force_cpu;

    // ------------------------------------------------------------------
    // Optional starvation guard
    // ------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_q, starve_d;

    // Counts consecutive cycles the CPU is waiting without a grant.
    always_comb begin
        starve_d = starve_q;
        if (!cpu_req || cpu_gnt) begin
            starve_d = 8'd0;
        end else begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= 8'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_cpu = cpu_req && (starve_q == 8'(STARVE_MAX));
`else
    assign force_cpu = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration: VGA wins unless the guard forces the CPU in.
    // Grants are suppressed while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        vga_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && (force_cpu || !vga_req)) begin
                cpu_gnt = 1'b1;
            end else if (vga_req) begin
                vga_gnt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next RAM command and stage-1 owner tag
    // ------------------------------------------------------------------
    always_comb begin
        mem_en_d    = vga_gnt | cpu_gnt;
        mem_we_d    = cpu_gnt & cpu_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tag1_d      = TAG_NONE;
        if (vga_gnt) begin
            mem_addr_d = vga_addr;
            tag1_d     = TAG_VGA;
        end else if (cpu_gnt) begin
            mem_addr_d = cpu_addr;
            if (cpu_we) begin
                mem_wdata_d = cpu_wdata;
            end else begin
                tag1_d = TAG_CPU;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers. Clearing the tags on reset discards in-flight reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            vga_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tag1_q       <= tag1_d;
            // Stage 2 lines up with the cycle the RAM drives mem_rdata.
            tag2_q       <= tag1_q;
            vga_rvalid_q <= (tag2_q == TAG_VGA);
            cpu_rvalid_q <= (tag2_q == TAG_CPU);
            if (tag2_q == TAG_VGA) begin
                vga_rdata_q <= mem_rdata;
            end
            if (tag2_q == TAG_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign vga_rvalid = vga_rvalid_q;
    assign vga_rdata  = vga_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
// ============================================================================
//  Module   : tb_vga_mem_arbiter
//  Purpose  : Self-checking bench for vga_mem_arbiter. A behavioural RAM
//             serves the DUT; a cycle-indexed reference model predicts
//             grants, the RAM command, and the read returns expected three
//             cycles after each read grant.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_mem_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    vga_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_gnt   (vga_gnt),
        .vga_rvalid(vga_rvalid),
        .vga_rdata (vga_rdata),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Background content of every RAM word until it is first written.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5AA5;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural single-port synchronous RAM
    // ------------------------------------------------------------------
    bit [15:0] ram     [0:65535];
    bit        written [0:65535];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
        end
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] shadow  [int];   // words written through the arbiter
    logic [15:0] exp_vga [int];   // cycle -> VGA data due that cycle
    logic [15:0] exp_cpu [int];   // cycle -> CPU data due that cycle
    logic [15:0] e_vrd, e_crd;    // last delivered data (held)
    logic        e_en, e_we, e_wd_known;
    logic [15:0] e_addr, e_wd;
    int          cpu_wait;
    logic        g_v, g_c;

    function automatic logic [15:0] model_read(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_vga.delete();
        exp_cpu.delete();
        e_vrd      = '0;
        e_crd      = '0;
        e_en       = 1'b0;
        e_we       = 1'b0;
        e_addr     = '0;
        e_wd       = '0;
        e_wd_known = 1'b1;
        cpu_wait   = 0;
    endtask

    // One clock cycle: check registered outputs, apply inputs, check grants,
    // and advance the model. gv/gc return the model's expected grants.
    task automatic step(input logic rs, input logic vr, input logic [15:0] va,
                        input logic cr, input logic cw, input logic [15:0] ca,
                        input logic [15:0] cd, output logic gv, output logic gc);
        logic force_c;
        logic evv, ecv;
        @(negedge clk);
        cyc++;
        reset = rs;
        if (rs) model_reset();
        #1;
        evv = exp_vga.exists(cyc);
        ecv = exp_cpu.exists(cyc);
        if (evv) e_vrd = exp_vga[cyc];
        if (ecv) e_crd = exp_cpu[cyc];
        chk("vga_rvalid", vga_rvalid, evv);
        chk("vga_rdata",  vga_rdata,  e_vrd);
        chk("cpu_rvalid", cpu_rvalid, ecv);
        chk("cpu_rdata",  cpu_rdata,  e_crd);
        chk("mem_en",     mem_en,     e_en);
        chk("mem_we",     mem_we,     e_we);
        chk("mem_addr",   mem_addr,   e_addr);
        if (e_wd_known) chk("mem_wdata", mem_wdata, e_wd);

        vga_req   = vr;
        vga_addr  = va;
        cpu_req   = cr;
        cpu_we    = cw;
        cpu_addr  = ca;
        cpu_wdata = cd;
        #1;
        force_c = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        force_c = cr && (cpu_wait == STARVE_MAX);
`endif
        gv = !rs && vr && !force_c;
        gc = !rs && cr && (!vr || force_c);
        chk("vga_gnt", vga_gnt, gv);
        chk("cpu_gnt", cpu_gnt, gc);

        e_en = gv || gc;
        e_we = gc && cw;
        if (gv) begin
            e_addr = va;
            e_wd_known = 1'b0;
            exp_vga[cyc + 3] = model_read(va);
        end else if (gc) begin
            e_addr = ca;
            if (cw) begin
                e_wd = cd;
                e_wd_known = 1'b1;
                shadow[ca] = cd;
            end else begin
                e_wd_known = 1'b0;
                exp_cpu[cyc + 3] = model_read(ca);
            end
        end
        cpu_wait = (rs || !cr || gc) ? 0 : cpu_wait + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, g_v, g_c);
    endtask

    // ------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------
    initial begin
        logic        vp, cp, cwe_p;
        logic [15:0] va_p, ca_p, cd_p;

        reset     = 1'b1;
        vga_req   = 1'b0;
        vga_addr  = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        model_reset();

        // Reset held, with requests present: no grants, outputs at zero.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 16'h0, g_v, g_c);

        // Idle after reset.
        idle(20);

        // CPU write then read-back.
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, g_v, g_c);
        idle(1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0, g_v, g_c);
        idle(5);
        chk("cpu_rdata_beef", cpu_rdata, 16'hBEEF);

        // Simultaneous requests: VGA first, CPU the cycle VGA drops.
        step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0041, 16'h0, g_v, g_c);
        step(1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 16'h0041, 16'h0, g_v, g_c);
        idle(4);

        // Interleaved reads on consecutive grants.
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0100, 16'h1111, g_v, g_c);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0200, 16'h2222, g_v, g_c);
        step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0101, 16'h3333, g_v, g_c);
        step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0,    16'h0, g_v, g_c);
        step(1'b0, 1'b0, 16'h0,    1'b1, 1'b0, 16'h0200, 16'h0, g_v, g_c);
        step(1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 16'h0,    16'h0, g_v, g_c);
        idle(5);
        chk("vga_rdata_3333", vga_rdata, 16'h3333);
        chk("cpu_rdata_2222", cpu_rdata, 16'h2222);

        // VGA saturating the port with a CPU read pending.
        cp = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 16'h0300 + 16'(i), cp, 1'b0, 16'h0020, 16'h0, g_v, g_c);
            if (g_c) cp = 1'b0;
        end
        if (cp) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, g_v, g_c);
        idle(5);

        // Reset one cycle after a VGA read grant: the read is dropped.
        step(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0, 16'h0, 16'h0, g_v, g_c);
        step(1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0, 16'h0, g_v, g_c);
        idle(5);
        step(1'b0, 1'b1, 16'h0051, 1'b0, 1'b0, 16'h0, 16'h0, g_v, g_c);
        idle(5);

        // Randomized traffic; each requester holds its request until granted.
        vp = 1'b0; cp = 1'b0; cwe_p = 1'b0;
        va_p = '0; ca_p = '0; cd_p = '0;
        for (int i = 0; i < 400; i++) begin
            if (!vp && ($urandom_range(0, 2) == 0)) begin
                vp   = 1'b1;
                va_p = 16'h0100 + 16'($urandom_range(0, 15));
            end
            if (!cp && ($urandom_range(0, 1) == 0)) begin
                cp    = 1'b1;
                cwe_p = 1'($urandom_range(0, 1));
                ca_p  = 16'h0100 + 16'($urandom_range(0, 15));
                cd_p  = 16'($urandom);
            end
            step(1'b0, vp, va_p, cp, cwe_p, ca_p, cd_p, g_v, g_c);
            if (g_v) vp = 1'b0;
            if (g_c) cp = 1'b0;
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
